// File: rtl/slice_alu_seq.sv
// -----------------------------------------------------------------------------
// slice_alu_seq
//
// Multi-precision ALU sequencer for the calculator datapath. A DATA_W-bit
// operation (DATA_W = SLICE_W*NSLICE) is carried out one SLICE_W-bit slice per
// clock through a single shared slice adder / logic unit.
//
//   ADD/SUB/AND/OR/XOR (and reserved codes) walk the slices LSB first and
//   always take NSLICE cycles.
//   LT (signed) walks the slices MSB first and stops at the first slice
//   that decides the outcome, so it takes 1..NSLICE cycles.
//
// Intermediate slices are collected in a shadow register. The visible
// result only changes together with done, so an operation chained through
// use_ans always reads the last completed result.
//
// Parameters:
//   SLICE_W  bits processed per cycle (default 8)
//   NSLICE   number of slices, >= 1 (default 2)
//
// Ports:
//   Clock    in   system clock, rising edge
//   Reset    in   asynchronous reset, active low
//   start    in   operation request, accepted only while ready=1
//   op       in   0=ADD 1=SUB 2=AND 3=OR 4=XOR 5=LT, 6/7 reserved (result 0)
//   use_ans  in   1: operand A is the current result instead of src_a
//   src_a    in   operand A (DATA_W)
//   src_b    in   operand B (DATA_W)
//   ready    out  high while idle
//   done     out  one-cycle pulse when result and flags update
//   result   out  registered result (DATA_W)
//   zero     out  full-width result is zero (0 for LT)
//   carry    out  carry out for ADD, no-borrow for SUB, 0 otherwise
//   compare  out  LT outcome, 0 for other ops
//   ovf      out  signed overflow of ADD/SUB
//
// Build option:
//   SLICE_ALU_OVF_EN  when defined, ovf reports signed overflow of ADD/SUB
//                     and updates on done; when undefined ovf is tied to 0.
// -----------------------------------------------------------------------------
module slice_alu_seq #(
  parameter int SLICE_W = 8,
  parameter int NSLICE  = 2
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        start,
  input  logic [2:0]                  op,
  input  logic                        use_ans,
  input  logic [SLICE_W*NSLICE-1:0]   src_a,
  input  logic [SLICE_W*NSLICE-1:0]   src_b,
  output logic                        ready,
  output logic                        done,
  output logic [SLICE_W*NSLICE-1:0]   result,
  output logic                        zero,
  output logic                        carry,
  output logic                        compare,
  output logic                        ovf
);

  localparam int DATA_W = SLICE_W * NSLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int MSB    = SLICE_W - 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LT  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN_UP,
    S_RUN_DOWN
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;
  logic [2:0]          op_reg;
  logic [IDX_W-1:0]    idx;
  logic                carry_q;
  logic [DATA_W-1:0]   shadow;

  // Slice unit signals
  logic [SLICE_W-1:0]  a_sl;
  logic [SLICE_W-1:0]  b_sl;
  logic [SLICE_W-1:0]  b_eff;
  logic                is_sub;
  logic                is_arith;
  logic                cin;
  logic [SLICE_W-1:0]  sum_sl;
  logic                sum_cout;
  logic [SLICE_W-1:0]  slice_res;
  logic [DATA_W-1:0]   merged;
  logic                last_up;

  // LT decision signals
  logic                lt_sign_diff;
  logic                lt_neq;
  logic                lt_finish;
  logic                lt_out;

`ifdef SLICE_ALU_OVF_EN
  logic                ovf_sl;
`endif

  // Shared slice datapath. The current slice of each operand is selected by
  // idx; SUB is formed as A + ~B + 1 with the +1 entering at slice 0 and the
  // registered carry chaining it through the higher slices.
  always_comb begin
    a_sl     = a_reg[idx*SLICE_W +: SLICE_W];
    b_sl     = b_reg[idx*SLICE_W +: SLICE_W];
    is_sub   = (op_reg == OP_SUB);
    is_arith = (op_reg == OP_ADD) || is_sub;
    b_eff    = is_sub ? ~b_sl : b_sl;
    cin      = (idx == '0) ? is_sub : carry_q;

    {sum_cout, sum_sl} = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin};

    case (op_reg)
      OP_ADD,
      OP_SUB:  slice_res = sum_sl;
      OP_AND:  slice_res = a_sl & b_sl;
      OP_OR:   slice_res = a_sl | b_sl;
      OP_XOR:  slice_res = a_sl ^ b_sl;
      default: slice_res = '0;
    endcase

    // Full-width view including the slice being produced this cycle, so the
    // final result and its zero flag are available on the last slice edge.
    merged = shadow;
    merged[idx*SLICE_W +: SLICE_W] = slice_res;

    last_up = (idx == LAST_IDX);
  end

  // Signed less-than, MSB slice first. Only the top slice carries the sign;
  // once sign bits agree, an unsigned slice compare gives the signed answer.
  always_comb begin
    lt_sign_diff = (idx == LAST_IDX) && (a_sl[MSB] != b_sl[MSB]);
    lt_neq       = (a_sl != b_sl);
    lt_finish    = lt_sign_diff || lt_neq || (idx == '0);
    if (lt_sign_diff) begin
      lt_out = a_sl[MSB];
    end else if (lt_neq) begin
      lt_out = (a_sl < b_sl);
    end else begin
      lt_out = 1'b0;
    end
  end

`ifdef SLICE_ALU_OVF_EN
  // Operands of equal sign producing a sum of the other sign; equivalent to
  // carry-into-MSB xor carry-out-of-MSB, and only meaningful on the top slice.
  always_comb begin
    ovf_sl = (a_sl[MSB] == b_eff[MSB]) && (sum_sl[MSB] != a_sl[MSB]);
  end
`else
  assign ovf = 1'b0;
`endif

  // Sequencer FSM with all outputs registered. done defaults low every cycle
  // so it only ever pulses for the single finishing edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= OP_ADD;
      idx     <= '0;
      carry_q <= 1'b0;
      shadow  <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      compare <= 1'b0;
`ifdef SLICE_ALU_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg   <= use_ans ? result : src_a;
            b_reg   <= src_b;
            op_reg  <= op;
            carry_q <= 1'b0;
            shadow  <= '0;
            ready   <= 1'b0;
            if (op == OP_LT) begin
              idx   <= LAST_IDX;
              state <= S_RUN_DOWN;
            end else begin
              idx   <= '0;
              state <= S_RUN_UP;
            end
          end
        end

        S_RUN_UP: begin
          shadow  <= merged;
          carry_q <= sum_cout;
          if (last_up) begin
            result  <= merged;
            zero    <= (merged == '0);
            carry   <= is_arith ? sum_cout : 1'b0;
            compare <= 1'b0;
`ifdef SLICE_ALU_OVF_EN
            ovf     <= is_arith ? ovf_sl : 1'b0;
`endif
            done    <= 1'b1;
            ready   <= 1'b1;
            state   <= S_IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        S_RUN_DOWN: begin
          if (lt_finish) begin
            result  <= DATA_W'(lt_out);
            zero    <= 1'b0;
            carry   <= 1'b0;
            compare <= lt_out;
`ifdef SLICE_ALU_OVF_EN
            ovf     <= 1'b0;
`endif
            done    <= 1'b1;
            ready   <= 1'b1;
            state   <= S_IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end

        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_slice_alu_seq
//
// Directed self-checking bench for slice_alu_seq with SLICE_W=8, NSLICE=2.
// Expected values are hand-computed constants. Expected ovf follows the
// SLICE_ALU_OVF_EN build option.
// -----------------------------------------------------------------------------
module tb_slice_alu_seq;

  localparam int SLICE_W = 8;
  localparam int NSLICE  = 2;
  localparam int DATA_W  = SLICE_W * NSLICE;
  localparam int MAX_CYC = 20;

`ifdef SLICE_ALU_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic              Clock;
  logic              Reset;
  logic              start;
  logic [2:0]        op;
  logic              use_ans;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              carry;
  logic              compare;
  logic              ovf;

  int evaluated = 0;
  int failures  = 0;
  int cycles;
  int done_count;

  slice_alu_seq #(
    .SLICE_W (SLICE_W),
    .NSLICE  (NSLICE)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .start   (start),
    .op      (op),
    .use_ans (use_ans),
    .src_a   (src_a),
    .src_b   (src_b),
    .ready   (ready),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .carry   (carry),
    .compare (compare),
    .ovf     (ovf)
  );

  // 10 ns clock
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // One comparison: counts it, and on mismatch counts and reports the failure
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    evaluated++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one operation and wait (bounded) for done; cycles counts the edges
  // after the start edge up to and including the one that raised done.
  task automatic applyStimulus(input logic [2:0] op_v, input logic ua,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    @(negedge Clock);
    op      = op_v;
    use_ans = ua;
    src_a   = a;
    src_b   = b;
    start   = 1'b1;
    @(posedge Clock);
    #1;
    start  = 1'b0;
    cycles = 0;
    while (!done && cycles < MAX_CYC) begin
      @(posedge Clock);
      #1;
      cycles++;
    end
  endtask

  // Full check of all result outputs right at the done cycle
  task automatic checkResult(input string tag, input int exp_cyc,
                             input logic [DATA_W-1:0] exp_res, input logic exp_zero,
                             input logic exp_carry, input logic exp_cmp, input logic exp_ovf);
    checkOutput({tag, "_done"},    32'(done),    32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles),  32'(exp_cyc));
    checkOutput({tag, "_result"},  32'(result),  32'(exp_res));
    checkOutput({tag, "_zero"},    32'(zero),    32'(exp_zero));
    checkOutput({tag, "_carry"},   32'(carry),   32'(exp_carry));
    checkOutput({tag, "_compare"}, 32'(compare), 32'(exp_cmp));
    checkOutput({tag, "_ovf"},     32'(ovf),     32'(exp_ovf));
  endtask

  initial begin
    Reset   = 1'b0;
    start   = 1'b0;
    op      = 3'd0;
    use_ans = 1'b0;
    src_a   = '0;
    src_b   = '0;

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    checkOutput("rst_ready",   32'(ready),   32'd1);
    checkOutput("rst_done",    32'(done),    32'd0);
    checkOutput("rst_result",  32'(result),  32'd0);
    checkOutput("rst_zero",    32'(zero),    32'd0);
    checkOutput("rst_carry",   32'(carry),   32'd0);
    checkOutput("rst_compare", 32'(compare), 32'd0);
    checkOutput("rst_ovf",     32'(ovf),     32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    // ADD with carry across the slice boundary
    applyStimulus(3'd0, 1'b0, 16'h00FF, 16'h0001);
    checkResult("add_ff_1", 2, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge Clock);
    #1;
    checkOutput("add_done_pulse", 32'(done),   32'd0);
    checkOutput("add_ready_back", 32'(ready),  32'd1);
    checkOutput("add_held",       32'(result), 32'h0100);

    // SUB: equal operands, then a borrow
    applyStimulus(3'd1, 1'b0, 16'h0005, 16'h0005);
    checkResult("sub_5_5", 2, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'd1, 1'b0, 16'h0003, 16'h0005);
    checkResult("sub_3_5", 2, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);

    // LT: sign difference decides in the top slice
    applyStimulus(3'd5, 1'b0, 16'hFFFF, 16'h0001);
    checkResult("lt_neg_pos", 1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(3'd5, 1'b0, 16'h0001, 16'hFFFF);
    checkResult("lt_pos_neg", 1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    // LT: decided in the low slice
    applyStimulus(3'd5, 1'b0, 16'h1234, 16'h1235);
    checkResult("lt_low", 2, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
    // LT: equal operands walk every slice
    applyStimulus(3'd5, 1'b0, 16'h1234, 16'h1234);
    checkResult("lt_eq", 2, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    // LT: same sign, top slice differs
    applyStimulus(3'd5, 1'b0, 16'h3400, 16'h12FF);
    checkResult("lt_top", 1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Logic ops and a reserved code
    applyStimulus(3'd2, 1'b0, 16'hF0F0, 16'h3C3C);
    checkResult("and", 2, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd4, 1'b0, 16'hFFFF, 16'hFFFF);
    checkResult("xor_zero", 2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd6, 1'b0, 16'h1234, 16'h5678);
    checkResult("reserved", 2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Chaining through the result register
    applyStimulus(3'd0, 1'b0, 16'h0010, 16'h0020);
    checkResult("chain_add", 2, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd3, 1'b1, 16'hAAAA, 16'h0F00);
    checkResult("chain_or", 2, 16'h0F30, 1'b0, 1'b0, 1'b0, 1'b0);

    // start held high through the run: exactly one done
    @(negedge Clock);
    op      = 3'd0;
    use_ans = 1'b0;
    src_a   = 16'h0101;
    src_b   = 16'h0202;
    start   = 1'b1;
    @(posedge Clock);
    #1;
    checkOutput("hold_ready_low", 32'(ready), 32'd0);
    done_count = 0;
    repeat (2) begin
      @(posedge Clock);
      #1;
      if (done) done_count++;
    end
    start = 1'b0;
    repeat (4) begin
      @(posedge Clock);
      #1;
      if (done) done_count++;
    end
    checkOutput("hold_done_count", 32'(done_count), 32'd1);
    checkOutput("hold_result",     32'(result),     32'h0303);

    // Reset pulsed mid-ADD: no done, outputs cleared
    @(negedge Clock);
    op    = 3'd0;
    src_a = 16'h1111;
    src_b = 16'h2222;
    start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    checkOutput("midrst_ready",  32'(ready),  32'd1);
    checkOutput("midrst_done",   32'(done),   32'd0);
    checkOutput("midrst_result", 32'(result), 32'd0);
    checkOutput("midrst_flags",  32'({zero, carry, compare, ovf}), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    done_count = 0;
    repeat (4) begin
      @(posedge Clock);
      #1;
      if (done) done_count++;
    end
    checkOutput("midrst_no_done", 32'(done_count), 32'd0);
    checkOutput("midrst_idle",    32'(ready),      32'd1);

    // Fresh operations after reset, including the signed overflow cases
    applyStimulus(3'd0, 1'b0, 16'h7FFF, 16'h0001);
    checkResult("ovf_add", 2, 16'h8000, 1'b0, 1'b0, 1'b0, OVF_EXP);
    applyStimulus(3'd1, 1'b0, 16'h8000, 16'h0001);
    checkResult("ovf_sub", 2, 16'h7FFF, 1'b0, 1'b1, 1'b0, OVF_EXP);
    applyStimulus(3'd0, 1'b0, 16'h0001, 16'h0001);
    checkResult("no_ovf_add", 2, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule

// File: doc/slice_alu_seq.md
Name: slice_alu_seq

Overview:
- Parametrised multi-precision ALU sequencer for the calculator datapath.
- Processes DATA_W = SLICE_W*NSLICE bit operands one SLICE_W slice per clock, using an internal slice adder/logic unit.
- Supports ADD, SUB, AND, OR, XOR and signed less-than (LT) with early termination.
- Sits between the key-scan front end (start/operands) and the seven-segment output (result/flags); supports accumulator chaining via use_ans.

Parameters:
- SLICE_W, 8: bits processed per cycle.
- NSLICE, 2: slice count; DATA_W = SLICE_W*NSLICE. Must be ≥1.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when ready=1.
- op  in  3  0=ADD 1=SUB 2=AND 3=OR 4=XOR 5=LT; 6,7 reserved.
- use_ans  in  1  1: operand A = current result register instead of src_a.
- src_a  in  DATA_W  operand A.
- src_b  in  DATA_W  operand B.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse when result/flags update.
- result  out  DATA_W  registered result (the ANS value).
- zero  out  1  result == 0 (ADD/SUB/AND/OR/XOR); 0 for LT.
- carry  out  1  final carry out (ADD); no-borrow (SUB); 0 otherwise.
- compare  out  1  LT outcome; 0 for other ops.
- ovf  out  1  signed overflow (see Optional Feature).

Behaviour:
- Reset (async, Reset=0): state IDLE; result, zero, carry, compare, ovf, done = 0; ready=1. Reset mid-operation aborts with no done pulse.
- IDLE:
  - On an edge with start=1, latch A (result if use_ans else src_a), B=src_b, and op; clear a slice index; ready goes 0.
  - start while not ready is ignored and is not queued.
- RUN_UP (ADD/SUB/AND/OR/XOR/reserved):
  - Slice i = 0..NSLICE-1 is processed on successive cycles, LSB first.
  - ADD: carry-in to slice 0 is 0. SUB: B slices inverted, carry-in to slice 0 is 1. Slice carry is registered between slices.
  - Logic ops: bitwise per slice.
  - Reserved ops: slice result is 0.
  - After the last slice edge, result, flags and done=1 all update on the same edge; state returns to IDLE (ready=1 on the next cycle).
  - Latency: start edge k → done high in the cycle after edge k+NSLICE.
- RUN_DOWN (LT, signed two's complement):
  - Slices are processed MSB first starting at slice NSLICE-1.
  - Top slice, sign bits differ: compare = A sign bit; finish immediately.
  - Any slice where A≠B (unsigned compare, after the sign check): compare = (A_slice < B_slice); finish.
  - Slices equal: move to the next lower slice. All slices equal: compare=0.
  - On finish: result = {0…, compare}, zero=0, carry=0.
  - Latency: 1..NSLICE cycles.
- Flags:
  - Held until the next done.
  - zero is evaluated on the full DATA_W result, not per slice.
- Intermediate slices are written to a shadow register. result changes only on done, so a chain using use_ans always sees the last completed result.
- NSLICE=1: every operation completes in 1 cycle.

Optional Feature:
- Macro SLICE_ALU_OVF_EN.
- Defined: ovf = signed overflow of the full-width ADD/SUB, i.e. carry into MSB XOR carry out of MSB. ovf is 0 for other ops and updates on done.
- Undefined: ovf is tied 0 and no overflow logic is synthesised.

Test Plan:
- ADD: NSLICE=2, 0x00FF + 0x0001 → result 0x0100, carry 0, zero 0; done exactly 2 cycles after the start edge.
- SUB: 0x0005 - 0x0005 → result 0x0000, zero 1, carry 1. Then 0x0003 - 0x0005 → 0xFFFE, carry 0.
- LT:
  - 0xFFFF vs 0x0001 → compare 1, done after 1 cycle.
  - 0x1234 vs 0x1235 → compare 1, done after 2 cycles.
  - 0x1234 vs 0x1234 → compare 0, result 0x0000.
- Chaining: ADD 0x0010+0x0020 (result 0x0030); then use_ans=1 with OR src_b=0x0F00 → 0x0F30, ignoring the src_a value 0xAAAA.
- Handshake and reset:
  - start held high during RUN → exactly one done per accepted start.
  - Reset pulsed low mid-ADD → no done; all outputs 0; ready=1.
  - A fresh ADD after reset completes normally.
- With SLICE_ALU_OVF_EN: 0x7FFF + 0x0001 → result 0x8000, ovf 1; 0x8000 - 0x0001 → ovf 1. Without the macro, ovf stays 0 for both.
